mc_core: RTL and testbench

Parametrised multicycle processor core, the successor to the single-cycle top level. It sequences fetch, execute, memory and write-back through an explicit state machine. Instruction and data memories are external, reached through valid/ready request ports, so wait-state memories are supported. Datapath width, PC width and data-address width are parameters; `start`/`halt` provide run control to the enclosing testbench or SoC.

---
 rtl/mc_core_pkg.sv | 35 +++
 rtl/mc_core_regfile.sv | 34 +++
 rtl/mc_core.sv | 201 ++++++++++++++++++++
 tb/tb_mc_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// Shared types and instruction field positions for the mc_core multicycle processor.
package mc_core_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_LD   = 3'd3,
      OP_ST   = 3'd4,
      OP_LI   = 3'd5,
      OP_BEQZ = 3'd6,
      OP_HALT = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   localparam int INSTR_W  = 9;
   localparam int NUM_REGS = 8;
   localparam int REG_AW   = 3;
   localparam int OPC_MSB  = 8;
   localparam int OPC_LSB  = 6;
   localparam int RD_MSB   = 5;
   localparam int RD_LSB   = 3;
   localparam int RS_MSB   = 2;
   localparam int RS_LSB   = 0;
   localparam int IMM_MSB  = 5;
   localparam int IMM_LSB  = 0;

endpackage

// File: rtl/mc_core_regfile.sv
// Eight-entry register file: two combinational read ports, one synchronous write port.
module mc_core_regfile
   import mc_core_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_r [NUM_REGS];

   // Register storage: cleared on reset, written on the enabled edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata_a = regs_r[raddr_a];
   assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/mc_core.sv
// Multicycle core sequencing FETCH/EXEC/MEM over valid/ready instruction and data ports.
// Defining MC_CORE_PERF_CNT_EN adds saturating cycle_cnt/retire_cnt outputs.
module mc_core
   import mc_core_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int PC_W     = 7,
   parameter int DADDR_W  = 8,
   parameter int START_PC = 0
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               start,
   output logic               halt,
   output logic               busy,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ready,
   input  logic [DATA_W-1:0]  dmem_rdata
`ifdef MC_CORE_PERF_CNT_EN
   ,
   output logic [31:0]        cycle_cnt,
   output logic [31:0]        retire_cnt
`endif
);

   localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
   localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

   state_e               state_r;
   logic [PC_W-1:0]      pc_r;
   logic [INSTR_W-1:0]   ir_r;

   opcode_e              opc_s;
   logic [REG_AW-1:0]    rd_s, rs_s, raddr_a_s, rf_waddr_s;
   logic [IMM_MSB:0]     imm_s;
   logic [DATA_W-1:0]    a_val_s, rs_val_s, alu_s, rf_wdata_s;
   logic                 rf_we_s, start_acc_s, mem_done_s;
   logic [PC_W-1:0]      pc_inc_s, pc_br_s, pc_next_s;

   assign opc_s       = opcode_e'(ir_r[OPC_MSB:OPC_LSB]);
   assign rd_s        = ir_r[RD_MSB:RD_LSB];
   assign rs_s        = ir_r[RS_MSB:RS_LSB];
   assign imm_s       = ir_r[IMM_MSB:IMM_LSB];
   // BEQZ tests r0, so port A is steered to r0 while a branch is decoded
   assign raddr_a_s   = (opc_s == OP_BEQZ) ? {REG_AW{1'b0}} : rd_s;
   assign pc_inc_s    = pc_r + PC_ONE;
   assign pc_br_s     = pc_r + PC_W'($signed(imm_s));
   assign pc_next_s   = ((opc_s == OP_BEQZ) && (a_val_s == {DATA_W{1'b0}})) ? pc_br_s : pc_inc_s;
   assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_HALTED));
   assign mem_done_s  = (state_r == ST_MEM) && dmem_ready;

   mc_core_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk     (CLK),
      .rst_n   (RST_N),
      .we      (rf_we_s),
      .waddr   (rf_waddr_s),
      .wdata   (rf_wdata_s),
      .raddr_a (raddr_a_s),
      .raddr_b (rs_s),
      .rdata_a (a_val_s),
      .rdata_b (rs_val_s)
   );

   // ALU result for the register-register opcodes
   always_comb begin
      alu_s = a_val_s;
      case (opc_s)
         OP_ADD:  alu_s = a_val_s + rs_val_s;
         OP_SUB:  alu_s = a_val_s - rs_val_s;
         OP_AND:  alu_s = a_val_s & rs_val_s;
         default: alu_s = a_val_s;
      endcase
   end

   // Register write port: ALU/LI on leaving EXEC, load data on leaving MEM
   always_comb begin
      rf_we_s    = 1'b0;
      rf_waddr_s = rd_s;
      rf_wdata_s = alu_s;
      if (state_r == ST_EXEC) begin
         case (opc_s)
            OP_ADD, OP_SUB, OP_AND: rf_we_s = 1'b1;
            OP_LI: begin
               rf_we_s    = 1'b1;
               rf_waddr_s = {REG_AW{1'b0}};
               rf_wdata_s = DATA_W'(imm_s);
            end
            default: rf_we_s = 1'b0;
         endcase
      end else if (mem_done_s && (opc_s == OP_LD)) begin
         rf_we_s    = 1'b1;
         rf_wdata_s = dmem_rdata;
      end else begin
         rf_we_s    = 1'b0;
      end
   end

   // Control FSM with registered request/status outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         pc_r       <= START_PC_V;
         ir_r       <= {INSTR_W{1'b0}};
         halt       <= 1'b0;
         busy       <= 1'b0;
         imem_req   <= 1'b0;
         imem_addr  <= {PC_W{1'b0}};
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= {DADDR_W{1'b0}};
         dmem_wdata <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_HALTED: begin
               if (start_acc_s) begin
                  state_r   <= ST_FETCH;
                  pc_r      <= START_PC_V;
                  imem_req  <= 1'b1;
                  imem_addr <= START_PC_V;
                  busy      <= 1'b1;
                  halt      <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  ir_r     <= imem_rdata;
                  imem_req <= 1'b0;
                  state_r  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (opc_s)
                  OP_LD, OP_ST: begin
                     state_r    <= ST_MEM;
                     dmem_req   <= 1'b1;
                     dmem_we    <= (opc_s == OP_ST);
                     dmem_addr  <= DADDR_W'(rs_val_s);
                     dmem_wdata <= a_val_s;
                  end
                  OP_HALT: begin
                     state_r <= ST_HALTED;
                     halt    <= 1'b1;
                     busy    <= 1'b0;
                  end
                  default: begin
                     state_r   <= ST_FETCH;
                     pc_r      <= pc_next_s;
                     imem_req  <= 1'b1;
                     imem_addr <= pc_next_s;
                  end
               endcase
            end
            ST_MEM: begin
               if (dmem_ready) begin
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  state_r   <= ST_FETCH;
                  pc_r      <= pc_inc_s;
                  imem_req  <= 1'b1;
                  imem_addr <= pc_inc_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef MC_CORE_PERF_CNT_EN
   logic retire_s;
   assign retire_s = ((state_r == ST_EXEC) && (opc_s != OP_LD) && (opc_s != OP_ST)) || mem_done_s;

   // Saturating busy-cycle and retired-instruction counters
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cycle_cnt  <= 32'd0;
         retire_cnt <= 32'd0;
      end else if (start_acc_s) begin
         cycle_cnt  <= 32'd0;
         retire_cnt <= 32'd0;
      end else begin
         if (busy && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (retire_s && (retire_cnt != 32'hFFFF_FFFF)) begin
            retire_cnt <= retire_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: program table, directed corner sequences and
// random programs checked against an instruction-level reference model.
module tb_mc_core;

   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_LD = 3'd3, A_ST = 3'd4;
   localparam logic [8:0] HALT_I = 9'b111_000_000;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       start = 1'b0;
   logic       halt, busy, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
   logic [6:0] imem_addr;
   logic [8:0] imem_rdata;
   logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
`ifdef MC_CORE_PERF_CNT_EN
   logic [31:0] cycle_cnt, retire_cnt;
`endif

   mc_core #(.DATA_W(8), .PC_W(7), .DADDR_W(8), .START_PC(0)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .halt(halt), .busy(busy),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
`ifdef MC_CORE_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // Memory models with configurable wait states
   logic [8:0] imem [128];
   logic [7:0] dmem [256];
   int iw_cfg = 0, dw_cfg = 0, iw_cnt = 0, dw_cnt = 0, gcyc = 0;
   assign imem_ready = imem_req && (iw_cnt == iw_cfg);
   assign imem_rdata = imem[imem_addr];
   assign dmem_ready = dmem_req && (dw_cnt == dw_cfg);
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge CLK) begin
      iw_cnt <= (imem_req && !imem_ready) ? iw_cnt + 1 : 0;
      dw_cnt <= (dmem_req && !dmem_ready) ? dw_cnt + 1 : 0;
      gcyc   <= gcyc + 1;
   end
   always @(posedge CLK) if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] = dmem_wdata;

   // Handshake monitor: stable request fields, request drop after ready, fetch log
   int fetch_q[$];
   int fetch_cyc[$];
   int stab_err = 0, stall_seen = 0;
   logic p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0, pi_req = 1'b0, pi_rdy = 1'b0;
   logic [7:0] p_addr = 8'd0, p_wd = 8'd0;
   logic [6:0] pi_addr = 7'd0;
   always @(negedge CLK) begin
      if (imem_req && imem_ready) begin
         fetch_q.push_back(int'(imem_addr));
         fetch_cyc.push_back(gcyc);
      end
      if (dmem_req && p_req && !p_rdy && (dmem_addr !== p_addr || dmem_we !== p_we || dmem_wdata !== p_wd)) stab_err++;
      if (imem_req && pi_req && !pi_rdy && imem_addr !== pi_addr) stab_err++;
      if ((p_req && p_rdy && dmem_req) || (pi_req && pi_rdy && imem_req)) stab_err++;
      if (dmem_req && !dmem_ready) stall_seen++;
      p_req = dmem_req; p_rdy = dmem_ready; p_we = dmem_we; p_addr = dmem_addr; p_wd = dmem_wdata;
      pi_req = imem_req; pi_rdy = imem_ready; pi_addr = imem_addr;
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] R(input logic [2:0] op, input int rd, input int rs);
      return {op, 3'(rd), 3'(rs)};
   endfunction
   function automatic logic [8:0] LI(input int imm);
      return {3'b101, 6'(imm)};
   endfunction
   function automatic logic [7:0] rf(input int i);
      return dut.u_rf.regs_r[i];
   endfunction

   task automatic load_halt();
      for (int i = 0; i < 128; i++) imem[i] = HALT_I;
   endtask

   task automatic do_reset();
      start = 1'b0;
      @(negedge CLK); RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // Start a program and count clock edges until halt; optional stray start at cycle 'poke'
   task automatic run_prog(input int poke, output int cyc);
      fetch_q.delete(); fetch_cyc.delete();
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0; cyc = 0;
      while (!halt && cyc < 4000) begin
         @(posedge CLK); #1; cyc++;
         start = (cyc == poke);
      end
      start = 1'b0;
      if (!halt) chk("halt_timeout", 64'd0, 64'd1);
   endtask

   // Instruction-level reference model
   logic [7:0] m_reg [8];
   logic [7:0] m_dmem [256];
   logic [7:0] t_reg [8];
   logic [7:0] t_dmem [256];

   function automatic int model_run(input int iw, input int dw);
      int pc, cyc, off;
      logic [8:0] ins;
      logic [2:0] rd, rs;
      for (int i = 0; i < 8; i++) t_reg[i] = m_reg[i];
      for (int i = 0; i < 256; i++) t_dmem[i] = m_dmem[i];
      pc = 0; cyc = 0;
      for (int step = 0; step < 300; step++) begin
         ins = imem[pc]; rd = ins[5:3]; rs = ins[2:0];
         cyc += 2 + iw;
         case (ins[8:6])
            3'd0: t_reg[rd] = t_reg[rd] + t_reg[rs];
            3'd1: t_reg[rd] = t_reg[rd] - t_reg[rs];
            3'd2: t_reg[rd] = t_reg[rd] & t_reg[rs];
            3'd3: begin t_reg[rd] = t_dmem[t_reg[rs]]; cyc += 1 + dw; end
            3'd4: begin t_dmem[t_reg[rs]] = t_reg[rd]; cyc += 1 + dw; end
            3'd5: t_reg[0] = {2'b00, ins[5:0]};
            3'd7: return cyc;
            default: ;
         endcase
         if (ins[8:6] == 3'd6 && t_reg[0] == 8'd0) begin
            off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            pc = (pc + off + 128) % 128;
         end else begin
            pc = (pc + 1) % 128;
         end
      end
      return -1;
   endfunction

   typedef struct {
      logic [7:0][8:0] prog;
      int              n;
      int              ridx;
      logic [7:0]      exp;
   } vec_t;

   function automatic vec_t mkv(input int n, input int ridx, input logic [7:0] exp,
                                input logic [8:0] i0, i1, i2, i3, i4, i5);
      vec_t v;
      v.prog = '{HALT_I, HALT_I, i5, i4, i3, i2, i1, i0};
      v.n = n; v.ridx = ridx; v.exp = exp;
      return v;
   endfunction

   vec_t vecs [6];

   initial begin
      int cyc, tries, exp_cyc, mism;
      vecs[0] = mkv(6, 0, 8'h00, LI(1), R(A_ADD,1,0), LI(0), R(A_SUB,0,1), R(A_ADD,0,1), HALT_I);
      vecs[1] = mkv(6, 0, 8'hFE, LI(1), R(A_ADD,1,0), LI(0), R(A_SUB,0,1), R(A_SUB,0,1), HALT_I);
      vecs[2] = mkv(6, 3, 8'd59, LI(63), R(A_ADD,3,0), R(A_ADD,3,3), R(A_ADD,3,3), R(A_ADD,3,0), HALT_I);
      vecs[3] = mkv(5, 4, 8'd10, LI(42), R(A_ADD,4,0), LI(15), R(A_AND,4,0), HALT_I, HALT_I);
      vecs[4] = mkv(3, 5, 8'hFB, LI(5), R(A_SUB,5,0), HALT_I, HALT_I, HALT_I, HALT_I);
      vecs[5] = mkv(2, 0, 8'h3F, LI(63), HALT_I, HALT_I, HALT_I, HALT_I, HALT_I);
      for (int i = 0; i < 256; i++) dmem[i] = 8'd0;
      load_halt();

      do_reset();
      chk("reset_outputs", {halt, busy, imem_req, dmem_req, dmem_we, imem_addr, dmem_addr, dmem_wdata}, 64'd0);

      for (int v = 0; v < 6; v++) begin
         do_reset(); load_halt();
         for (int k = 0; k < 8; k++) imem[k] = vecs[v].prog[k];
         run_prog(-1, cyc);
         chk($sformatf("vec%0d_cycles", v), cyc, 2 * vecs[v].n);
         chk($sformatf("vec%0d_reg", v), rf(vecs[v].ridx), vecs[v].exp);
      end

      // LI 5; ADD r1,r0 twice; HALT, with a stray start while busy
      do_reset(); load_halt();
      imem[0] = LI(5); imem[1] = R(A_ADD,1,0); imem[2] = R(A_ADD,1,0);
      run_prog(3, cyc);
      chk("prog1_halt_cycles", cyc, 8);
      chk("prog1_r1", rf(1), 8'd10);
`ifdef MC_CORE_PERF_CNT_EN
      chk("perf_retire", retire_cnt, 32'd4);
      chk("perf_cycle", cycle_cnt, 32'd8);
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      chk("perf_clear", {cycle_cnt, retire_cnt}, 64'd0);
      for (int k = 0; k < 50 && !halt; k++) begin @(posedge CLK); #1; end
`endif

      // Store then load with two data wait states
      do_reset(); load_halt(); dw_cfg = 2;
      imem[0] = LI(7); imem[1] = R(A_ADD,1,0); imem[2] = LI(9);
      imem[3] = R(A_ST,0,1); imem[4] = R(A_LD,2,1);
      run_prog(-1, cyc);
      chk("stld_cycles", cyc, 18);
      chk("st_latency", fetch_cyc[4] - fetch_cyc[3], 5);
      chk("ld_latency", fetch_cyc[5] - fetch_cyc[4], 5);
      chk("stld_mem", dmem[7], 8'd9);
      chk("stld_r2", rf(2), 8'd9);
      chk("stld_stalls_seen", stall_seen >= 4, 1'b1);
      dw_cfg = 0;

      // BEQZ -2 at PC 0: taken wraps to 126, not taken falls through to 1
      do_reset(); load_halt();
      imem[0] = {3'b110, 6'h3E}; imem[126] = LI(3);
      run_prog(-1, cyc);
      chk("beqz_taken_addr", fetch_q[1], 126);
      chk("beqz_taken_cycles", cyc, 6);
      run_prog(-1, cyc);
      chk("beqz_nt_addr", fetch_q[1], 1);
      chk("beqz_nt_cycles", cyc, 4);

      // Reset asserted while a data request is pending
      do_reset(); load_halt(); dw_cfg = 20;
      imem[0] = R(A_LD,2,0);
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      for (int k = 0; k < 10 && !dmem_req; k++) begin @(posedge CLK); #1; end
      chk("mem_reached", dmem_req, 1'b1);
      #2; RST_N = 1'b0; #1;
      chk("midop_reset_outputs", {halt, busy, imem_req, dmem_req, dmem_we, imem_addr, dmem_addr, dmem_wdata}, 64'd0);
      @(negedge CLK); RST_N = 1'b1; dw_cfg = 0;
      run_prog(-1, cyc);
      chk("restart_pc", fetch_q[0], 0);
      chk("restart_cycles", cyc, 5);

      // Random programs against the reference model, state carried across runs
      do_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
      for (int i = 0; i < 256; i++) begin dmem[i] = 8'($urandom); m_dmem[i] = dmem[i]; end
      for (int t = 0; t < 15; t++) begin
         iw_cfg = $urandom_range(0, 2); dw_cfg = $urandom_range(0, 2);
         exp_cyc = -1; tries = 0;
         while (exp_cyc < 0 && tries < 50) begin
            load_halt();
            for (int p = 0; p < 16; p++) imem[p] = 9'($urandom_range(0, 511));
            exp_cyc = model_run(iw_cfg, dw_cfg);
            tries++;
         end
         if (exp_cyc < 0) begin
            load_halt();
            exp_cyc = model_run(iw_cfg, dw_cfg);
         end
         for (int i = 0; i < 8; i++) m_reg[i] = t_reg[i];
         for (int i = 0; i < 256; i++) m_dmem[i] = t_dmem[i];
         run_prog(-1, cyc);
         chk($sformatf("rand%0d_cycles", t), cyc, exp_cyc);
         mism = 0;
         for (int i = 0; i < 8; i++) if (rf(i) !== m_reg[i]) mism++;
         chk($sformatf("rand%0d_regs", t), mism, 0);
         mism = 0;
         for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) mism++;
         chk($sformatf("rand%0d_dmem", t), mism, 0);
      end

      chk("handshake_stability", stab_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
